// File: rtl/pwm_multi_channel_if.sv
// Register bus bundle for the multi-channel PWM block: strobes, address, write and read data.
interface pwm_multi_channel_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int ADDR_W = $clog2(NUM_CH) + 2;

  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  wdata;
  logic [CNT_W-1:0]  rdata;

  modport master (output wr_en, rd_en, addr, wdata, input rdata);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/pwm_multi_channel.sv
// NUM_CH independent edge/center-aligned PWM channels behind a small register bus.
// Define PWM_DOUBLE_BUFFER_EN to stage PERIOD/ON_TIME writes until the next period boundary.
module pwm_multi_channel #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pwm_multi_channel_if.slave    bus,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic [NUM_CH-1:0]     period_tick
);
  localparam int ADDR_W = $clog2(NUM_CH) + 2;
  localparam logic [1:0] REG_PERIOD = 2'd0;
  localparam logic [1:0] REG_ONTIME = 2'd1;
  localparam logic [1:0] REG_CONFIG = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state     [NUM_CH];
  state_t           w_stateNext [NUM_CH];
  logic [CNT_W-1:0] r_period    [NUM_CH];
  logic [CNT_W-1:0] r_onTime    [NUM_CH];
  logic [CNT_W-1:0] r_count     [NUM_CH];
  logic [CNT_W-1:0] w_countNext [NUM_CH];
  logic [CNT_W-1:0] w_periodRead[NUM_CH];
  logic [CNT_W-1:0] w_onTimeRead[NUM_CH];
`ifdef PWM_DOUBLE_BUFFER_EN
  logic [CNT_W-1:0] r_periodShadow [NUM_CH];
  logic [CNT_W-1:0] r_onTimeShadow [NUM_CH];
  logic [NUM_CH-1:0] w_load;
`endif

  logic [NUM_CH-1:0] r_enable, r_mode, r_invert, r_done, r_dirDown, r_tick, r_pwm;
  logic [NUM_CH-1:0] w_wrSel, w_enNext, w_dirNext, w_tickNext, w_raw;
  logic [ADDR_W-1:0] w_addrCh;
  logic [1:0]        w_addrReg;
  logic [CNT_W-1:0]  w_rdVal;

  assign w_addrCh    = bus.addr >> 2;
  assign w_addrReg   = bus.addr[1:0];
  assign pwm_out     = r_pwm;
  assign period_tick = r_tick;

  // Channel addresses at or beyond NUM_CH never match, so those writes fall away.
  always_comb begin
    w_wrSel  = '0;
    w_enNext = r_enable;
    for (int c = 0; c < NUM_CH; c++) begin
      w_wrSel[c] = bus.wr_en && (w_addrCh == ADDR_W'(c));
      if (w_wrSel[c] && (w_addrReg == REG_CONFIG)) begin
        w_enNext[c] = bus.wdata[0];
      end
    end
  end

  always_comb begin
    w_raw = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_period[c] == '0) begin
        w_raw[c] = 1'b0;
      end else if (r_onTime[c] >= r_period[c]) begin
        w_raw[c] = 1'b1;
      end else begin
        w_raw[c] = (r_count[c] < r_onTime[c]);
      end
    end
  end

  // Center mode holds at both ends so each count value appears twice per 2*P period;
  // the boundary is the arrival at 0 on the way down, or any count left out of range.
  always_comb begin
    w_dirNext  = r_dirDown;
    w_tickNext = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_stateNext[c] = r_state[c];
      w_countNext[c] = r_count[c];
      case (r_state[c])
        IDLE: begin
          w_countNext[c] = '0;
          w_dirNext[c]   = 1'b0;
          if (w_enNext[c]) w_stateNext[c] = RUN;
        end
        RUN: begin
          if (!w_enNext[c]) begin
            w_stateNext[c] = IDLE;
            w_countNext[c] = '0;
            w_dirNext[c]   = 1'b0;
          end else if (r_period[c] == '0) begin
            w_countNext[c] = '0;
            w_dirNext[c]   = 1'b0;
          end else if (!r_mode[c]) begin
            w_dirNext[c] = 1'b0;
            if (r_count[c] >= r_period[c] - CNT_W'(1)) begin
              w_countNext[c] = '0;
              w_tickNext[c]  = 1'b1;
            end else begin
              w_countNext[c] = r_count[c] + CNT_W'(1);
            end
          end else if (r_count[c] >= r_period[c]) begin
            w_countNext[c] = '0;
            w_dirNext[c]   = 1'b1;
            w_tickNext[c]  = 1'b1;
          end else if (!r_dirDown[c]) begin
            if (r_count[c] == r_period[c] - CNT_W'(1)) begin
              w_dirNext[c]  = 1'b1;
              w_tickNext[c] = (r_period[c] == CNT_W'(1));
            end else begin
              w_countNext[c] = r_count[c] + CNT_W'(1);
            end
          end else if (r_count[c] == '0) begin
            w_dirNext[c] = 1'b0;
          end else begin
            w_countNext[c] = r_count[c] - CNT_W'(1);
            w_tickNext[c]  = (r_count[c] == CNT_W'(1));
          end
        end
        default: w_stateNext[c] = IDLE;
      endcase
    end
  end

`ifdef PWM_DOUBLE_BUFFER_EN
  always_comb begin
    w_load = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_load[c] = (w_stateNext[c] == RUN) && ((r_state[c] == IDLE) || w_tickNext[c]);
      w_periodRead[c] = r_periodShadow[c];
      w_onTimeRead[c] = r_onTimeShadow[c];
    end
  end
`else
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_periodRead[c] = r_period[c];
      w_onTimeRead[c] = r_onTime[c];
    end
  end
`endif

  always_comb begin
    w_rdVal = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_addrCh == ADDR_W'(c)) begin
        case (w_addrReg)
          REG_PERIOD: w_rdVal = w_periodRead[c];
          REG_ONTIME: w_rdVal = w_onTimeRead[c];
          REG_CONFIG: w_rdVal = CNT_W'({r_invert[c], r_mode[c], r_enable[c]});
          default:    w_rdVal = CNT_W'({r_done[c], (r_state[c] == RUN)});
        endcase
      end
    end
  end

  // A tick in the same cycle as a STATUS clear keeps period_done set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c]  <= IDLE;
        r_period[c] <= '0;
        r_onTime[c] <= '0;
        r_count[c]  <= '0;
`ifdef PWM_DOUBLE_BUFFER_EN
        r_periodShadow[c] <= '0;
        r_onTimeShadow[c] <= '0;
`endif
      end
      r_enable  <= '0;
      r_mode    <= '0;
      r_invert  <= '0;
      r_done    <= '0;
      r_dirDown <= '0;
      r_tick    <= '0;
      r_pwm     <= '0;
      bus.rdata <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c]   <= w_stateNext[c];
        r_count[c]   <= w_countNext[c];
        r_dirDown[c] <= w_dirNext[c];
        r_tick[c]    <= w_tickNext[c];
        r_pwm[c]     <= (r_state[c] == RUN) ? (w_raw[c] ^ r_invert[c]) : r_invert[c];
        if (w_wrSel[c] && (w_addrReg == REG_CONFIG)) begin
          r_enable[c] <= bus.wdata[0];
          r_mode[c]   <= bus.wdata[1];
          r_invert[c] <= bus.wdata[2];
        end
        if (w_tickNext[c]) begin
          r_done[c] <= 1'b1;
        end else if (w_wrSel[c] && (w_addrReg == REG_STATUS) && bus.wdata[1]) begin
          r_done[c] <= 1'b0;
        end
`ifdef PWM_DOUBLE_BUFFER_EN
        if (w_wrSel[c] && (w_addrReg == REG_PERIOD)) r_periodShadow[c] <= bus.wdata;
        if (w_wrSel[c] && (w_addrReg == REG_ONTIME)) r_onTimeShadow[c] <= bus.wdata;
        if (w_load[c]) begin
          r_period[c] <= r_periodShadow[c];
          r_onTime[c] <= r_onTimeShadow[c];
        end
`else
        if (w_wrSel[c] && (w_addrReg == REG_PERIOD)) r_period[c] <= bus.wdata;
        if (w_wrSel[c] && (w_addrReg == REG_ONTIME)) r_onTime[c] <= bus.wdata;
`endif
      end
      if (bus.rd_en) bus.rdata <= w_rdVal;
    end
  end
endmodule
